// File: rtl/csel_a8.sv
// rtl/csel_a8.sv - 8-bit carry-select adder with a registered output stage.
// Optional carry-in port cin is enabled by defining CSEL_A8_CIN_EN.
module csel_a8 #(
   parameter int BLK_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] sum,
   output logic       cout,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       in_valid,
   output logic       out_valid
`ifdef CSEL_A8_CIN_EN
   ,
   input  logic       cin
`endif
);

   localparam int NBLK = 8 / BLK_W;

   logic             w_cin_eff;
   logic [7:0]       w_sum;
   logic             w_c;
   logic             w_c0;
   logic             w_c1;
   logic [BLK_W-1:0] w_s0;
   logic [BLK_W-1:0] w_s1;

   logic [7:0]       r_sum;
   logic             r_cout;
   logic             r_valid;

`ifdef CSEL_A8_CIN_EN
   assign w_cin_eff = cin;
`else
   assign w_cin_eff = 1'b0;
`endif

   // Full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   // Block 0 ripples from cin; every higher block precomputes both carry-in
   // cases and the incoming block carry picks one.
   always_comb begin
      w_sum = '0;
      w_c   = w_cin_eff;
      w_c0  = 1'b0;
      w_c1  = 1'b1;
      w_s0  = '0;
      w_s1  = '0;
      for (int k = 0; k < NBLK; k++) begin
         if (k == 0) begin
            for (int i = 0; i < BLK_W; i++)
               {w_c, w_sum[i]} = fa(a[i], b[i], w_c);
         end else begin
            w_c0 = 1'b0;
            w_c1 = 1'b1;
            for (int i = 0; i < BLK_W; i++) begin
               {w_c0, w_s0[i]} = fa(a[k*BLK_W+i], b[k*BLK_W+i], w_c0);
               {w_c1, w_s1[i]} = fa(a[k*BLK_W+i], b[k*BLK_W+i], w_c1);
            end
            w_sum[k*BLK_W +: BLK_W] = w_c ? w_s1 : w_s0;
            w_c = w_c ? w_c1 : w_c0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= 8'h00;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_c;
         end
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_csel_a8.sv
// tb/tb_csel_a8.sv - randomized and directed bench for csel_a8, BLK_W=4 and BLK_W=2.
// Define CSEL_A8_CIN_EN to exercise the carry-in port and the exhaustive sweep.
module tb_csel_a8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic       in_valid;
   logic       cin;
   logic [7:0] sum4, sum2;
   logic       cout4, cout2, ov4, ov2;

   logic [7:0] m_sum;
   logic       m_cout, m_valid;
   int         n_total = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   csel_a8 #(.BLK_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .sum(sum4), .cout(cout4), .a(a), .b(b),
      .in_valid(in_valid), .out_valid(ov4)
`ifdef CSEL_A8_CIN_EN
      , .cin(cin)
`endif
   );

   csel_a8 #(.BLK_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .sum(sum2), .cout(cout2), .a(a), .b(b),
      .in_valid(in_valid), .out_valid(ov2)
`ifdef CSEL_A8_CIN_EN
      , .cin(cin)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_w4"}, {22'd0, ov4, cout4, sum4}, {22'd0, m_valid, m_cout, m_sum});
      chk({tag, "_w2"}, {22'd0, ov2, cout2, sum2}, {22'd0, m_valid, m_cout, m_sum});
   endtask

   function automatic logic cin_eff(input logic c);
`ifdef CSEL_A8_CIN_EN
      return c;
`else
      return 1'b0;
`endif
   endfunction

   // Drive one cycle of inputs, advance the reference on the edge, check 1 time unit later.
   task automatic step(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic iv, input logic ic);
      int total;
      a = ia; b = ib; in_valid = iv; cin = ic;
      @(posedge clk);
      if (rst_n) begin
         if (iv) begin
            total  = int'(ia) + int'(ib) + int'(cin_eff(ic));
            m_sum  = total[7:0];
            m_cout = total[8];
         end
         m_valid = iv;
      end
      #1 check_all(tag);
   endtask

   task automatic rst_pulse();
      #2 rst_n = 1'b0;
      #1;
      m_sum = 8'h00; m_cout = 1'b0; m_valid = 1'b0;
      check_all("rst_async");
      @(posedge clk);
      #1 check_all("rst_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; a = 8'h00; b = 8'h00; in_valid = 1'b0; cin = 1'b0;
      m_sum = 8'h00; m_cout = 1'b0; m_valid = 1'b0;
      #1 check_all("reset_init");
      @(posedge clk);
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      #1 check_all("reset_clocked");
      rst_n = 1'b1;

      step("a0_a0", 8'hA0, 8'hA0, 1'b1, 1'b0);
      chk("a0_a0_const", {23'd0, cout4, sum4}, {23'd0, 1'b1, 8'h40});

      step("b2b_1", 8'h58, 8'hF4, 1'b1, 1'b0);
      chk("b2b_1_const", {23'd0, cout4, sum4}, 32'h14C);
      step("b2b_2", 8'h3D, 8'h0F, 1'b1, 1'b0);
      chk("b2b_2_const", {23'd0, cout4, sum4}, 32'h04C);
      step("b2b_3", 8'hCA, 8'hC8, 1'b1, 1'b0);
      chk("b2b_3_const", {23'd0, cout4, sum4}, 32'h192);

      step("hold_0", 8'hA6, 8'hF4, 1'b1, 1'b0);
      step("hold_1", 8'h12, 8'h34, 1'b0, 1'b0);
      step("hold_2", 8'h56, 8'h78, 1'b0, 1'b0);
      chk("hold_const", {22'd0, ov4, cout4, sum4}, {22'd0, 1'b0, 1'b1, 8'h9A});

      step("rst_mid_1", 8'hF3, 8'hCC, 1'b1, 1'b0);
      chk("rst_mid_1_const", {23'd0, cout2, sum2}, 32'h1BF);
      step("rst_mid_2", 8'hF3, 8'h57, 1'b1, 1'b0);
      chk("rst_mid_2_const", {23'd0, cout2, sum2}, 32'h14A);
      rst_pulse();

      // A valid input pending when reset hits must not surface after release.
      a = 8'h11; b = 8'h22; in_valid = 1'b1;
      rst_pulse();
      step("post_rst_idle", 8'h00, 8'h00, 1'b0, 1'b0);
      step("post_rst_first", 8'h80, 8'h80, 1'b1, 1'b0);
      step("post_rst_next", 8'hFF, 8'h01, 1'b1, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 699) rst_pulse();
         step("rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
      end

`ifdef CSEL_A8_CIN_EN
      step("cin_ff", 8'hFF, 8'h00, 1'b1, 1'b1);
      chk("cin_ff_const", {23'd0, cout4, sum4}, 32'h100);
      for (int p = 0; p < 65536; p++)
         step("sweep", p[7:0], p[15:8], 1'b1, p[0] ^ p[15] ^ p[4]);
`else
      for (int p = 0; p < 4096; p++)
         step("sweep", p[7:0] ^ 8'($urandom), p[11:4], 1'b1, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/csel_a8.md
CSEL_A8 -- requirements
Module: csel_a8

Interface
REQ-001 Parameter BLK_W, default 4: carry-select block width in bits; legal values 2 and 4 only (must divide 8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sum  output  8  registered sum bits [7:0].
REQ-005 cout  output  1  registered carry out of bit 7.
REQ-006 a  input  8  addend A.
REQ-007 b  input  8  addend B.
REQ-008 in_valid  input  1  a/b (and cin when present) valid this cycle.
REQ-009 out_valid  output  1  sum/cout hold a newly computed result.
REQ-010 Port order SHALL be clk, rst_n, sum, cout, a, b, in_valid, out_valid, then cin when present.

Function
REQ-011 Result SHALL equal {cout,sum} = a + b + cin_eff, computed as a 9-bit unsigned sum; cin_eff = cin when present, else 0.
REQ-012 Lowest block (bits BLK_W-1:0) SHALL be a ripple-carry adder fed by cin_eff.
REQ-013 Each higher block SHALL contain two ripple-carry adders, one with carry-in 0 and one with carry-in 1, built from full-adder cells.
REQ-014 Each higher block's sum bits and carry-out SHALL be selected by a 2:1 mux driven by the previous block's selected carry-out.
REQ-015 cout SHALL be the selected carry-out of the top block.
REQ-016 Adder datapath SHALL be purely combinational from a, b, cin_eff; only the output stage is registered.
REQ-017 On a rising clk edge with in_valid=1, sum and cout SHALL load the combinational result and out_valid SHALL become 1.
REQ-018 On a rising clk edge with in_valid=0, sum and cout SHALL hold their values and out_valid SHALL become 0.
REQ-019 Latency SHALL be exactly 1 cycle from in_valid sample to out_valid; back-to-back in_valid SHALL give one result per cycle, with no stall or backpressure.
REQ-020 Overflow SHALL wrap modulo 256 in sum, with the 9th bit in cout; there is no saturation.

Reset
REQ-021 While rst_n=0, sum SHALL be 8'h00, cout SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard any pending result; the first in_valid sampled after release SHALL produce out_valid one cycle later.
REQ-023 Deassertion of rst_n is synchronized externally; the block SHALL take no action on the deassertion edge itself.

Configuration
REQ-024 Macro CSEL_A8_CIN_EN defined: the block SHALL add port cin (input, 1 bit, carry-in into bit 0), sampled with a and b.
REQ-025 Macro CSEL_A8_CIN_EN undefined: port cin SHALL be absent and carry-in SHALL be constant 0.

Verification
REQ-026 Reset then a=8'hA0, b=8'hA0, in_valid=1 -> next cycle sum=8'h40, cout=1, out_valid=1.
REQ-027 Back-to-back inputs 58+F4, 3D+0F, CA+C8 -> sum/cout results 4C/1, 4C/0, 92/1 on consecutive cycles, each 1 cycle after its input.
REQ-028 Input A6+F4 followed by in_valid=0 for 2 cycles -> sum=9A, cout=1 held; out_valid=1 for one cycle then 0.
REQ-029 Inputs F3+CC then F3+57 -> BF/1 then 4A/1; assert rst_n=0 between clock edges -> outputs 0 immediately.
REQ-030 With CSEL_A8_CIN_EN defined: FF+00 with cin=1 -> sum=00, cout=1; run an exhaustive 65536-pair sweep for both cin values and both BLK_W values against a+b+cin.
